wb_interconnect_nx: RTL and testbench

//   Parametrised single-master Wishbone B4 (pipelined) interconnect for the accelerator SoC.

---
 rtl/wb_interconnect_nx.sv | 140 ++++++++++++++
 tb/tb_wb_interconnect_nx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wb_interconnect_nx.sv
// wb_interconnect_nx: single-master Wishbone B4 pipelined interconnect with base/mask decode; define WB_TIMEOUT_EN for a bus timeout.
module wb_interconnect_nx #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {4{32'hF000_0000}},
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_DATA = 32'hDEAD_BEEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_wb_cyc,
  input  logic                             i_wb_stb,
  input  logic                             i_wb_we,
  input  logic [DATA_WIDTH/8-1:0]          i_wb_sel,
  input  logic [ADDR_WIDTH-1:0]            i_wb_addr,
  input  logic [DATA_WIDTH-1:0]            i_wb_data,
  output logic [DATA_WIDTH-1:0]            o_wb_data,
  output logic                             o_wb_ack,
  output logic                             o_wb_err,
  output logic                             o_wb_stall,
  output logic [NUM_SLAVES-1:0]            o_s_cyc,
  output logic [NUM_SLAVES-1:0]            o_s_stb,
  output logic                             o_s_we,
  output logic [DATA_WIDTH/8-1:0]          o_s_sel,
  output logic [ADDR_WIDTH-1:0]            o_s_addr,
  output logic [DATA_WIDTH-1:0]            o_s_data,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_s_data,
  input  logic [NUM_SLAVES-1:0]            i_s_ack,
  input  logic [NUM_SLAVES-1:0]            i_s_stall
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, hit_idx;
  logic we_q, we_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d, g_data;
  logic ack_q, ack_d, err_q, err_d;
  logic [NUM_SLAVES-1:0] grant_oh;
  logic hit, busy, g_ack, g_stall, done, expired;
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if ((i_wb_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
  end
  assign busy = state_q == REQ || state_q == WAIT;
  assign grant_oh = NUM_SLAVES'(1) << grant_q;
  assign g_ack = i_s_ack[grant_q];
  assign g_stall = i_s_stall[grant_q];
  assign g_data = i_s_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign done = g_ack && (state_q == WAIT || !g_stall);
`ifdef WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = busy ? cnt_q + 1'b1 : '0;
  assign expired = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign expired = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    we_d = we_q;
    sel_d = sel_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (i_wb_cyc && i_wb_stb) begin
        state_d = hit ? REQ : ERR;
        grant_d = hit_idx;
        we_d = i_wb_we;
        sel_d = i_wb_sel;
        addr_d = i_wb_addr;
        wdata_d = i_wb_data;
      end
      REQ, WAIT: if (!i_wb_cyc) state_d = IDLE;
      else if (done) begin
        state_d = IDLE;
        ack_d = 1'b1;
        rdata_d = g_data;
      end else if (expired) begin
        state_d = IDLE;
        err_d = 1'b1;
        rdata_d = DEFAULT_DATA;
      end else if (state_q == REQ && !g_stall) state_d = WAIT;
      ERR: begin
        state_d = IDLE;
        err_d = 1'b1;
        rdata_d = DEFAULT_DATA;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      we_q <= 1'b0;
      sel_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q <= we_d;
      sel_q <= sel_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q <= ack_d;
      err_q <= err_d;
    end
  assign o_wb_data = rdata_q;
  assign o_wb_ack = ack_q;
  assign o_wb_err = err_q;
  assign o_wb_stall = state_q != IDLE;
  assign o_s_cyc = busy ? grant_oh : '0;
  assign o_s_stb = state_q == REQ ? grant_oh : '0;
  assign o_s_we = we_q;
  assign o_s_sel = sel_q;
  assign o_s_addr = addr_q;
  assign o_s_data = wdata_q;
endmodule

// File: tb/tb_wb_interconnect_nx.sv
// tb_wb_interconnect_nx: scoreboard bench with randomized transactions against a window-decode reference model.
module tb_wb_interconnect_nx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
  logic [3:0] i_wb_sel = '0;
  logic [31:0] i_wb_addr = '0, i_wb_data = '0;
  logic [31:0] o_wb_data, o_s_addr, o_s_data;
  logic o_wb_ack, o_wb_err, o_wb_stall, o_s_we;
  logic [3:0] o_s_cyc, o_s_stb, o_s_sel;
  logic [127:0] i_s_data = '0;
  logic [3:0] i_s_ack = '0, i_s_stall = '0;
  int n_tests = 0, n_fail = 0, cyc_n = 0;
  typedef struct { bit is_err; logic [31:0] data; int at; } exp_t;
  exp_t sb[$];
  logic [31:0] last_data = '0;
  logic [31:0] base [4] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
  localparam logic [31:0] MASK = 32'hF000_0000;
  wb_interconnect_nx #(
    .NUM_SLAVES(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .SLAVE_BASE({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SLAVE_MASK({4{32'hF000_0000}}),
    .TIMEOUT_CYCLES(8), .DEFAULT_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst(rst_n),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we), .i_wb_sel(i_wb_sel),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_wb_data(o_wb_data), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err), .o_wb_stall(o_wb_stall),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we), .o_s_sel(o_s_sel),
    .o_s_addr(o_s_addr), .o_s_data(o_s_data),
    .i_s_data(i_s_data), .i_s_ack(i_s_ack), .i_s_stall(i_s_stall)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask
  task automatic push(input bit is_err, input logic [31:0] data, input int at);
    exp_t e;
    e.is_err = is_err;
    e.data = data;
    e.at = at;
    sb.push_back(e);
  endtask
  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++) if ((a & MASK) == base[i]) return i;
    return -1;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) last_data = '0;
    else begin
      if (o_wb_ack || o_wb_err) begin
        if (sb.size() == 0) chk("unexpected_resp", {o_wb_ack, o_wb_err}, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_kind", {o_wb_ack, o_wb_err}, e.is_err ? 2'b01 : 2'b10);
          chk("resp_data", o_wb_data, e.data);
          chk("resp_cycle", cyc_n, e.at);
          last_data = e.data;
        end
      end else chk("data_hold", o_wb_data, last_data);
      chk("cyc_onehot", $countones(o_s_cyc) <= 1, 1);
    end
  end
  task automatic txn(input logic [31:0] addr, input bit we, input logic [3:0] sel, input logic [31:0] wdata,
                     input int nstall, input int dack, input logic [31:0] rdata, input int ab);
    int g = decode(addr);
    logic [3:0] oh;
    oh = g < 0 ? 4'b0 : 4'(1 << g);
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    i_wb_we = we;
    i_wb_sel = sel;
    i_wb_addr = addr;
    i_wb_data = wdata;
    if (g < 0) push(1'b1, 32'hDEAD_BEEF, cyc_n + 2);
    @(posedge clk); #1;
    i_wb_stb = 1'b0;
    i_wb_we = 1'($urandom);
    i_wb_sel = 4'($urandom);
    i_wb_addr = $urandom;
    i_wb_data = $urandom;
    if (g < 0) begin
      @(negedge clk);
      chk("miss_no_cyc", o_s_cyc, 0);
      chk("miss_stall", o_wb_stall, 1);
      @(posedge clk); #1;
    end else begin
      for (int t = 0; t <= nstall + dack; t++) begin
        logic [3:0] sv, av;
        sv = 4'($urandom);
        av = 4'($urandom);
        sv[g] = t < nstall;
        av[g] = (t == nstall + dack) || (t == ab);
        i_s_stall = sv;
        i_s_ack = av;
        i_s_data = {$urandom, $urandom, $urandom, $urandom};
        i_s_data[g*32 +: 32] = rdata;
        i_wb_cyc = t != ab;
        if (t == nstall + dack && t != ab) push(1'b0, rdata, cyc_n + 1);
        @(negedge clk);
        chk("s_cyc", o_s_cyc, oh);
        chk("s_stb", o_s_stb, t <= nstall ? oh : 4'b0);
        chk("s_addr", o_s_addr, addr);
        chk("s_data", o_s_data, wdata);
        chk("s_we", o_s_we, we);
        chk("s_sel", o_s_sel, sel);
        chk("busy_stall", o_wb_stall, 1);
        @(posedge clk); #1;
        if (t == ab) break;
      end
    end
    i_wb_cyc = 1'b0;
    i_s_ack = 4'($urandom);
    i_s_stall = 4'($urandom);
    @(negedge clk);
    chk("idle_cyc", o_s_cyc, 0);
    chk("idle_stall", o_wb_stall, 0);
    @(posedge clk); #1;
    i_s_ack = '0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_data", o_wb_data, 0);
    chk("rst_ack_err", {o_wb_ack, o_wb_err}, 0);
    chk("rst_stall", o_wb_stall, 0);
    chk("rst_cyc_stb", {o_s_cyc, o_s_stb}, 0);
    chk("rst_bcast", {o_s_we, o_s_sel, o_s_addr, o_s_data}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    txn(32'h1000_0004, 1'b1, 4'hF, 32'h1234_5678, 0, 2, 32'h0BAD_0001, -1);
    txn(32'h2000_0010, 1'b0, 4'hF, 32'h0, 3, 1, 32'hCAFE_F00D, -1);
    txn(32'h5000_0000, 1'b0, 4'hF, 32'h0, 0, 0, 32'h0, -1);
    txn(32'h0000_0040, 1'b0, 4'h3, 32'h0, 0, 2, 32'h1111_2222, 1);
    txn(32'h3000_0000, 1'b1, 4'h1, 32'h55, 2, 0, 32'h7777_8888, -1);
`ifdef WB_TIMEOUT_EN
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    i_wb_addr = 32'h3000_0100;
    push(1'b1, 32'hDEAD_BEEF, cyc_n + 9);
    @(posedge clk); #1;
    i_wb_stb = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    @(negedge clk);
    chk("timeout_cyc_low", o_s_cyc, 0);
    i_wb_cyc = 1'b0;
    @(posedge clk); #1;
`else
    txn(32'h3000_0100, 1'b0, 4'hF, 32'h0, 0, 400, 32'h0, 300);
`endif
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    i_wb_we = 1'b0;
    i_wb_addr = 32'h1000_0008;
    @(posedge clk); #1;
    i_wb_stb = 1'b0;
    i_s_stall = '0;
    i_s_ack = '0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rstw_cyc_stb", {o_s_cyc, o_s_stb}, 0);
    chk("rstw_stall", o_wb_stall, 0);
    chk("rstw_ack_err", {o_wb_ack, o_wb_err}, 0);
    chk("rstw_data", o_wb_data, 0);
    chk("rstw_bcast", {o_s_we, o_s_sel, o_s_addr, o_s_data}, 0);
    i_wb_cyc = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    txn(32'h1000_0020, 1'b0, 4'hF, 32'h0, 1, 1, 32'hA5A5_5A5A, -1);
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int ab;
      a = {4'($urandom_range(0, 5)), 28'($urandom)};
      ab = $urandom_range(0, 4) == 0 ? int'($urandom_range(0, 6)) : -1;
      repeat ($urandom_range(0, 2)) begin
        i_s_ack = 4'($urandom);
        @(posedge clk); #1;
      end
      i_s_ack = '0;
      txn(a, 1'($urandom), 4'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, ab);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
